// File: rtl/operand_fetch_stage_if.sv
// Operand fetch stage bundle: decoded-instruction input, writeback port,
// and the valid/ready operand slot feeding the ALU.
interface operand_fetch_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [4:0]        sa;
    logic [15:0]       imm;
    logic              use_sa;
    logic              use_imm;
    logic              sext;
    logic [3:0]        aluc_in;
    logic              flush;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rn;
    logic [DATA_W-1:0] wb_d;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [3:0]        aluc;

    modport master (
        output in_valid, rs, rt, sa, imm, use_sa, use_imm, sext, aluc_in,
        output flush, wb_we, wb_rn, wb_d, out_ready,
        input  in_ready, out_valid, opa, opb, aluc
    );

    modport slave (
        input  in_valid, rs, rt, sa, imm, use_sa, use_imm, sext, aluc_in,
        input  flush, wb_we, wb_rn, wb_d, out_ready,
        output in_ready, out_valid, opa, opb, aluc
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Register-read stage: 2R1W register file with writeback bypass, operand
// select, and a one-entry valid/ready slot driving the ALU inputs.
module operand_fetch_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_fetch_stage_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_rf [NREG];
    logic              r_valid;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [3:0]        r_aluc;

    logic              w_wr_ok;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rs;
    logic [DATA_W-1:0] w_rt;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_opa_sel;
    logic [DATA_W-1:0] w_opb_sel;

    assign w_wr_ok = bus.wb_we && ((bus.wb_rn != '0) || !R0_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_rf[bus.wb_rn] <= bus.wb_d;
        end
    end

    // Same-cycle writeback wins over the array; index 0 overrides both.
    always_comb begin
        w_rs = r_rf[bus.rs];
        if (w_wr_ok && (bus.wb_rn == bus.rs)) begin
            w_rs = bus.wb_d;
        end
        if (R0_ZERO && (bus.rs == '0)) begin
            w_rs = '0;
        end
    end

    always_comb begin
        w_rt = r_rf[bus.rt];
        if (w_wr_ok && (bus.wb_rn == bus.rt)) begin
            w_rt = bus.wb_d;
        end
        if (R0_ZERO && (bus.rt == '0)) begin
            w_rt = '0;
        end
    end

    assign w_imm_ext = bus.sext ? {{(DATA_W-16){bus.imm[15]}}, bus.imm}
                                : {{(DATA_W-16){1'b0}}, bus.imm};
    assign w_opa_sel = bus.use_sa ? {{(DATA_W-5){1'b0}}, bus.sa} : w_rs;
    assign w_opb_sel = bus.use_imm ? w_imm_ext : w_rt;

    assign w_in_ready = !r_valid || bus.out_ready || bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_aluc  <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_opa   <= w_opa_sel;
            r_opb   <= w_opb_sel;
            r_aluc  <= bus.aluc_in;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.opa       = r_opa;
    assign bus.opb       = r_opb;
    assign bus.aluc      = r_aluc;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: stimulus pushes expected
// operand triples, a negedge monitor pops them on each output transfer.
module tb_operand_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    operand_fetch_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    operand_fetch_stage #(
        .DATA_W (32),
        .ADDR_W (5),
        .R0_ZERO(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [3:0]  aluc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.flush) begin
                if (q.size() > 0) void'(q.pop_front());
            end else if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_opa", bus.opa, e.opa);
                    chk("sb_opb", bus.opb, e.opb);
                    chk("sb_aluc", {28'd0, bus.aluc}, {28'd0, e.aluc});
                end
            end
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] sa, input logic [15:0] imm,
                         input logic use_sa, input logic use_imm,
                         input logic sext, input logic [3:0] aluc);
        bus.rs       = rs;
        bus.rt       = rt;
        bus.sa       = sa;
        bus.imm      = imm;
        bus.use_sa   = use_sa;
        bus.use_imm  = use_imm;
        bus.sext     = sext;
        bus.aluc_in  = aluc;
        bus.in_valid = 1'b1;
    endtask

    task automatic handshake(input logic [31:0] ea, input logic [31:0] eb,
                             input logic [3:0] ec);
        exp_t e;
        bit   ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.opa  = ea;
                e.opb  = eb;
                e.aluc = ec;
                q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("handshake_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] sa, input logic [15:0] imm,
                        input logic use_sa, input logic use_imm,
                        input logic sext, input logic [3:0] aluc,
                        input logic [31:0] ea, input logic [31:0] eb);
        drive(rs, rt, sa, imm, use_sa, use_imm, sext, aluc);
        handshake(ea, eb, aluc);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.use_sa   = 1'b0;
        bus.use_imm  = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rn, input logic [31:0] d);
        bus.wb_we = 1'b1;
        bus.wb_rn = rn;
        bus.wb_d  = d;
        @(posedge clk);
        #1;
        bus.wb_we = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.sa        = '0;
        bus.imm       = '0;
        bus.use_sa    = 1'b0;
        bus.use_imm   = 1'b0;
        bus.sext      = 1'b0;
        bus.aluc_in   = '0;
        bus.flush     = 1'b0;
        bus.wb_we     = 1'b0;
        bus.wb_rn     = '0;
        bus.wb_d      = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_opa", bus.opa, 32'd0);
        chk("rst_opb", bus.opb, 32'd0);
        chk("rst_aluc", {28'd0, bus.aluc}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back reads of every register after reset.
        for (int i = 1; i < 32; i++) begin
            send(5'(i), 5'(i), 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'(i),
                 32'd0, 32'd0);
        end
        idle();

        wb_write(5'd5, 32'h1234_5678);
        send(5'd5, 5'd5, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0,
             32'h1234_5678, 32'h1234_5678);
        idle();

        bus.wb_we = 1'b1;
        bus.wb_rn = 5'd7;
        bus.wb_d  = 32'hCAFE_F00D;
        send(5'd7, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd2,
             32'hCAFE_F00D, 32'd0);
        bus.wb_we = 1'b0;
        send(5'd7, 5'd7, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd4,
             32'hCAFE_F00D, 32'hCAFE_F00D);

        send(5'd5, 5'd0, 5'd0, 16'h8001, 1'b0, 1'b1, 1'b1, 4'd3,
             32'h1234_5678, 32'hFFFF_8001);
        send(5'd5, 5'd0, 5'd0, 16'h8001, 1'b0, 1'b1, 1'b0, 4'd3,
             32'h1234_5678, 32'h0000_8001);
        send(5'd5, 5'd0, 5'd0, 16'h7FFF, 1'b0, 1'b1, 1'b1, 4'd5,
             32'h1234_5678, 32'h0000_7FFF);
        send(5'd0, 5'd5, 5'd31, 16'd0, 1'b1, 1'b0, 1'b0, 4'd6,
             32'h0000_001F, 32'h1234_5678);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Stall: held slot frozen even across a write to its source reg.
        bus.out_ready = 1'b0;
        send(5'd5, 5'd7, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd9,
             32'h1234_5678, 32'hCAFE_F00D);
        drive(5'd7, 5'd5, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'hA);
        bus.wb_we = 1'b1;
        bus.wb_rn = 5'd5;
        bus.wb_d  = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_opa", bus.opa, 32'h1234_5678);
            chk("stall_opb", bus.opb, 32'hCAFE_F00D);
            chk("stall_aluc", {28'd0, bus.aluc}, 32'd9);
            @(posedge clk);
            #1;
            bus.wb_we = 1'b0;
        end
        bus.out_ready = 1'b1;
        handshake(32'hCAFE_F00D, 32'h5555_5555, 4'hA);
        idle();

        wb_write(5'd0, 32'hFFFF_FFFF);
        send(5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1,
             32'd0, 32'd0);
        bus.wb_we = 1'b1;
        bus.wb_rn = 5'd0;
        bus.wb_d  = 32'hFFFF_FFFF;
        send(5'd0, 5'd5, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1,
             32'd0, 32'h5555_5555);
        bus.wb_we = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Flush while stalled drops both the held and the offered beat.
        bus.out_ready = 1'b0;
        send(5'd7, 5'd7, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1,
             32'hCAFE_F00D, 32'hCAFE_F00D);
        idle();
        @(posedge clk);
        #1;
        drive(5'd5, 5'd5, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd7);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(5'd5, 5'd7, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd8,
             32'h5555_5555, 32'hCAFE_F00D);
        idle();

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
